m7_ctrl: RTL and testbench
==========================

# m7_ctrl

Mode 7 register controller for the PPU. Decodes CPU writes to the Mode 7 registers through the shared Mode 7 write-twice latch and keeps a staging copy of the parameters. It commits that copy to the `bg7` datapath only on dot-group boundaries, so the A/B and C/D multiplies of one pixel always use the same parameter set. It also owns the signed M7A × M7B-high product that the CPU reads back at $2134–$2136.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `reg_we`  in  1  one-cycle write strobe from the B-bus decoder
- `reg_addr`  in  8  register offset from $2100
- `reg_wdata`  in  8  write data
- `rd_addr`  in  8  read offset from $2100
- `reg_rdata`  out  8  product byte for `rd_addr` $34/$35/$36, else 8'h00
- `rd_hit`  out  1  `rd_addr` ∈ {$34, $35, $36}
- `dot_ctr`  in  3  sub-dot counter shared with `bg7`
- `render`  in  1  1 = active display; 0 = vblank or forced blank
- `m7sel`  out  4  {screen-over[1:0], yflip, xflip}
- `m7_a`, `m7_b`, `m7_c`, `m7_d`  out  16 each  committed matrix
- `m7_xofs`, `m7_yofs`, `m7_xorig`, `m7_yorig`  out  13 each  committed offsets and origin
- `commit_pending`  out  1  staging copy differs from committed copy

## Operation
- **Latch.** `m7_old` (8 bit) is shared by $0D, $0E and $1B–$20. On a write to any of these, the 16-bit value is {wdata, m7_old}, then `m7_old` ← wdata.
- **$0D / $0E.** Staged xofs / yofs ← value[12:0]. This block ignores the BG1 use of these addresses.
- **$1A.** Staged m7sel ← {wdata[7:6], wdata[1], wdata[0]}. This write does not use or update `m7_old`.
- **$1B / $1C / $1D / $1E.** Staged A / B / C / D ← value.
- **$1F / $20.** Staged xorig / yorig ← value[12:0].
- **Other addresses.** Writes to any other address change nothing, including `m7_old`.
- **Commit strobe.** commit = (~render) | (dot_ctr == 3'd7). On commit, every output register loads the staging value.
  - If a write and a commit land in the same cycle, the commit loads the post-write staging value (bypass).
  - Result: the new value appears on the outputs on the next clock edge.
- **Multiply.** Any write to $1B or $1C starts a product on the next clock edge:
  - mpy[23:0] ← $signed(staged A) × $signed(staged B[15:8]), using the post-write values.
  - Result width is 24 bit, signed, never saturated.
- **Read-back.** `reg_rdata` is combinational from the mpy register: $34 → mpy[7:0], $35 → mpy[15:8], $36 → mpy[23:16].
- **`commit_pending`.** Registered; equals 1 whenever the staging and committed copies differ.
- **Reset.** Asserted asynchronously, it clears:
  - staging copy, committed copy, `m7_old` and mpy to 0
  - `commit_pending` to 0, therefore `reg_rdata` reads 0 and all parameter outputs are 0.

  Deasserting reset mid-frame resumes normal operation with no pending state.

## Timing
- **Write to staging:** 1 cycle.
- **Staging to output:**
  - render = 1: 1 to 8 cycles, settling at the first commit edge.
  - render = 0: exactly 1 cycle.
- **Guarantee to `bg7`:** outputs change only on the edge that follows dot_ctr == 7. The values sampled at dot_ctr 0 and 1 therefore always come from the same set.
- **Product:** valid 1 cycle after the write to $1B/$1C. A read in that same cycle returns the previous product.
- **Back-to-back writes:** each write updates `m7_old` in order, with no stall and no lost write.
- **No handshake:** writes are fire-and-forget.

## Structure
- **Constants in `ppu_pkg`:** `M7SEL_ADDR`, `M7A_ADDR` … `M7Y_ADDR`, `M7HOFS_ADDR`, `M7VOFS_ADDR`, `MPYL_ADDR`/`MPYM_ADDR`/`MPYH_ADDR`.
- **Typedef in `ppu_pkg`:** `m7_params_t`, a packed struct holding m7sel, A–D, xofs, yofs, xorig, yorig. Both the staging and committed copies use this type.
- **Sub-module:** one natural sub-module, `m7_mpy`, a registered signed 16×8 multiplier with a load enable.

## Test plan
- **Latch pairing.** Write $1B ← 8'h34, then $1B ← 8'h12 with render = 0 → `m7_a` = 16'h1234 two cycles later; `m7_old` = 8'h12.
- **Product read-back.** Write A = 16'hFF00 (−256), then $1C ← 8'h00 then 8'h03 → mpy = 24'hFFFD00. Reads at $34/$35/$36 return 8'h00 / 8'hFD / 8'hFF.
- **Mid-dot commit.** render = 1, write C at dot_ctr = 2 → `m7_c` unchanged until the edge after dot_ctr = 7, then updated. `commit_pending` is 1 in between.
- **Write during commit.** Write $20 second byte at dot_ctr = 7 → `m7_yorig` updates on that same edge with value[12:0]; `commit_pending` stays 0.
- **M7SEL mapping.** Write $1A ← 8'hC3 → `m7sel` = 4'hF. The next $1B write pairs with the `m7_old` value from before the $1A write.
- **Reset mid-operation.** Assert reset asynchronously between the two writes of a pair → all outputs and `reg_rdata` read 0 immediately. After release, a single $1B ← 8'h55 followed by a commit gives `m7_a` = 16'h5500.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU definitions for the Mode 7 register controller.
// Holds the B-bus register offsets (relative to $2100) that the Mode 7 block
// decodes, and the parameter bundle type used for both the staging and the
// committed copies of the Mode 7 state.
package ppu_pkg;

  localparam logic [7:0] M7HOFS_ADDR = 8'h0D;
  localparam logic [7:0] M7VOFS_ADDR = 8'h0E;
  localparam logic [7:0] M7SEL_ADDR  = 8'h1A;
  localparam logic [7:0] M7A_ADDR    = 8'h1B;
  localparam logic [7:0] M7B_ADDR    = 8'h1C;
  localparam logic [7:0] M7C_ADDR    = 8'h1D;
  localparam logic [7:0] M7D_ADDR    = 8'h1E;
  localparam logic [7:0] M7X_ADDR    = 8'h1F;
  localparam logic [7:0] M7Y_ADDR    = 8'h20;
  localparam logic [7:0] MPYL_ADDR   = 8'h34;
  localparam logic [7:0] MPYM_ADDR   = 8'h35;
  localparam logic [7:0] MPYH_ADDR   = 8'h36;

  typedef struct packed {
    logic [3:0]  sel;    // {screen-over[1:0], yflip, xflip}
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [12:0] xofs;
    logic [12:0] yofs;
    logic [12:0] xorig;
    logic [12:0] yorig;
  } m7_params_t;

  function automatic logic is_mpy_rd(input logic [7:0] addr);
    return (addr == MPYL_ADDR) || (addr == MPYM_ADDR) || (addr == MPYH_ADDR);
  endfunction

endpackage

// File: rtl/m7_mpy.sv
// m7_mpy: registered signed 16x8 multiplier with load enable.
// Ports:
//   clk, reset   clock and asynchronous active-low reset (clears product)
//   load_i       capture a new product on the next edge
//   a_i          signed 16-bit multiplicand
//   b_i          signed 8-bit multiplier
//   p_o          registered signed 24-bit product (never saturated)
module m7_mpy (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  b_i,
  output logic [23:0] p_o
);

  logic [23:0] p_q;
  logic [23:0] p_d;
  logic [23:0] a_ext;
  logic [23:0] b_ext;

  // Sign-extend both operands to the full result width; the low 24 bits of
  // the unsigned product then equal the signed product exactly.
  assign a_ext = {{8{a_i[15]}}, a_i};
  assign b_ext = {{16{b_i[7]}}, b_i};

  always_comb begin
    p_d = p_q;
    if (load_i) begin
      p_d = a_ext * b_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/m7_ctrl.sv
// m7_ctrl: Mode 7 register controller.
// Decodes CPU writes to the Mode 7 registers through the shared write-twice
// latch into a staging copy, and commits that copy to the bg7 outputs only on
// dot-group boundaries (or at any time outside active display). Also owns the
// signed M7A x M7B-high product read back at $2134-$2136.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   reg_we/addr/wdata CPU write strobe, offset from $2100, data
//   rd_addr           read offset; reg_rdata/rd_hit return product bytes
//   dot_ctr, render   sub-dot counter and active-display flag (commit timing)
//   m7sel, m7_a..d, m7_xofs/yofs/xorig/yorig   committed parameters
//   commit_pending    staging copy differs from committed copy
module m7_ctrl
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  reg_rdata,
  output logic        rd_hit,
  input  logic [2:0]  dot_ctr,
  input  logic        render,
  output logic [3:0]  m7sel,
  output logic [15:0] m7_a,
  output logic [15:0] m7_b,
  output logic [15:0] m7_c,
  output logic [15:0] m7_d,
  output logic [12:0] m7_xofs,
  output logic [12:0] m7_yofs,
  output logic [12:0] m7_xorig,
  output logic [12:0] m7_yorig,
  output logic        commit_pending
);

  m7_params_t staging_q, staging_d;
  m7_params_t active_q, active_d;
  logic [7:0] old_q, old_d;
  logic       pending_q, pending_d;
  logic [15:0] wval;
  logic       commit;
  logic       mpy_load;
  logic [23:0] mpy;

  assign wval   = {reg_wdata, old_q};
  assign commit = ~render | (dot_ctr == 3'd7);

  always_comb begin
    staging_d = staging_q;
    old_d     = old_q;
    mpy_load  = 1'b0;
    if (reg_we) begin
      case (reg_addr)
        M7HOFS_ADDR: begin staging_d.xofs  = wval[12:0]; old_d = reg_wdata; end
        M7VOFS_ADDR: begin staging_d.yofs  = wval[12:0]; old_d = reg_wdata; end
        // M7SEL bypasses the latch entirely.
        M7SEL_ADDR:  staging_d.sel = {reg_wdata[7:6], reg_wdata[1], reg_wdata[0]};
        M7A_ADDR:    begin staging_d.a = wval; old_d = reg_wdata; mpy_load = 1'b1; end
        M7B_ADDR:    begin staging_d.b = wval; old_d = reg_wdata; mpy_load = 1'b1; end
        M7C_ADDR:    begin staging_d.c = wval; old_d = reg_wdata; end
        M7D_ADDR:    begin staging_d.d = wval; old_d = reg_wdata; end
        M7X_ADDR:    begin staging_d.xorig = wval[12:0]; old_d = reg_wdata; end
        M7Y_ADDR:    begin staging_d.yorig = wval[12:0]; old_d = reg_wdata; end
        default:     ;
      endcase
    end
    // Commit takes the post-write staging value so a write landing on the
    // boundary cycle is not deferred by a whole dot group.
    active_d  = commit ? staging_d : active_q;
    pending_d = (staging_d != active_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staging_q <= '0;
      active_q  <= '0;
      old_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      staging_q <= staging_d;
      active_q  <= active_d;
      old_q     <= old_d;
      pending_q <= pending_d;
    end
  end

  // Operands are the post-write staging values of A and B[15:8].
  m7_mpy u_mpy (
    .clk    (clk),
    .reset  (reset),
    .load_i (mpy_load),
    .a_i    (staging_d.a),
    .b_i    (staging_d.b[15:8]),
    .p_o    (mpy)
  );

  always_comb begin
    reg_rdata = 8'h00;
    case (rd_addr)
      MPYL_ADDR: reg_rdata = mpy[7:0];
      MPYM_ADDR: reg_rdata = mpy[15:8];
      MPYH_ADDR: reg_rdata = mpy[23:16];
      default:   reg_rdata = 8'h00;
    endcase
  end

  assign rd_hit         = is_mpy_rd(rd_addr);
  assign m7sel          = active_q.sel;
  assign m7_a           = active_q.a;
  assign m7_b           = active_q.b;
  assign m7_c           = active_q.c;
  assign m7_d           = active_q.d;
  assign m7_xofs        = active_q.xofs;
  assign m7_yofs        = active_q.yofs;
  assign m7_xorig       = active_q.xorig;
  assign m7_yorig       = active_q.yorig;
  assign commit_pending = pending_q;

endmodule

// File: tb/tb_m7_ctrl.sv
// Testbench for m7_ctrl: directed test-plan sequences plus randomized traffic,
// checked through an expectation queue drained by an independent monitor.
module tb_m7_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_we = 1'b0;
  logic [7:0]  reg_addr = 8'h00;
  logic [7:0]  reg_wdata = 8'h00;
  logic [7:0]  rd_addr = 8'h00;
  logic [7:0]  reg_rdata;
  logic        rd_hit;
  logic [2:0]  dot_ctr = 3'd0;
  logic        render = 1'b0;
  logic [3:0]  m7sel;
  logic [15:0] m7_a, m7_b, m7_c, m7_d;
  logic [12:0] m7_xofs, m7_yofs, m7_xorig, m7_yorig;
  logic        commit_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m7_ctrl dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .rd_addr(rd_addr), .reg_rdata(reg_rdata),
    .rd_hit(rd_hit), .dot_ctr(dot_ctr), .render(render), .m7sel(m7sel),
    .m7_a(m7_a), .m7_b(m7_b), .m7_c(m7_c), .m7_d(m7_d),
    .m7_xofs(m7_xofs), .m7_yofs(m7_yofs), .m7_xorig(m7_xorig),
    .m7_yorig(m7_yorig), .commit_pending(commit_pending)
  );

  // ---------------- reference model ----------------
  // Registers held as full 16-bit values indexed by their $21xx offset; the
  // 13-bit fields are truncated only when viewed as outputs.
  logic [15:0] stg [logic [7:0]];
  logic [15:0] cmt [logic [7:0]];
  logic [7:0]  m_old;
  logic [23:0] m_mpy;
  logic [7:0]  regs [9] = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20, 8'h0D, 8'h0E};

  typedef struct packed {
    logic [131:0] params;
    logic         pend;
    logic [7:0]   rd;
    logic         hit;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_clear();
    foreach (regs[i]) begin
      stg[regs[i]] = 16'h0;
      cmt[regs[i]] = 16'h0;
    end
    m_old = 8'h00;
    m_mpy = 24'h0;
  endtask

  function automatic logic [131:0] view(input logic [15:0] r [logic [7:0]]);
    logic [15:0] s;
    logic [3:0]  sel;
    s   = r[8'h1A];
    sel = {s[7:6], s[1], s[0]};
    return {sel, r[8'h1B], r[8'h1C], r[8'h1D], r[8'h1E],
            r[8'h0D][12:0], r[8'h0E][12:0], r[8'h1F][12:0], r[8'h20][12:0]};
  endfunction

  task automatic model_step(input bit we, input logic [7:0] a, input logic [7:0] d,
                            input bit rnd, input logic [2:0] dot, input logic [7:0] ra);
    exp_t e;
    int   pa, pb, prod;
    logic [15:0] bv;
    if (!reset) begin
      model_clear();
    end else begin
      if (we) begin
        if (a == 8'h1A) begin
          stg[a] = {8'h00, d};
        end else if (a == 8'h0D || a == 8'h0E || (a >= 8'h1B && a <= 8'h20)) begin
          stg[a] = {d, m_old};
          m_old  = d;
        end
        if (a == 8'h1B || a == 8'h1C) begin
          pa   = $signed(stg[8'h1B]);
          bv   = stg[8'h1C];
          pb   = $signed(bv[15:8]);
          prod = pa * pb;
          m_mpy = prod[23:0];
        end
      end
      if (!rnd || dot == 3'd7) begin
        foreach (regs[i]) cmt[regs[i]] = stg[regs[i]];
      end
    end
    e.params = view(cmt);
    e.pend   = (view(stg) != view(cmt));
    e.hit    = (ra == 8'h34 || ra == 8'h35 || ra == 8'h36);
    e.rd     = (ra == 8'h34) ? m_mpy[7:0] : (ra == 8'h35) ? m_mpy[15:8] :
               (ra == 8'h36) ? m_mpy[23:16] : 8'h00;
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit we, input logic [7:0] a, input logic [7:0] d,
                      input bit rnd, input logic [2:0] dot, input logic [7:0] ra);
    @(negedge clk);
    reg_we = we; reg_addr = a; reg_wdata = d;
    render = rnd; dot_ctr = dot; rd_addr = ra;
    model_step(we, a, d, rnd, dot, ra);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [131:0] dut_params();
    return {m7sel, m7_a, m7_b, m7_c, m7_d, m7_xofs, m7_yofs, m7_xorig, m7_yorig};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_params() !== e.params) begin
          errors++;
          $display("FAIL params got %h want %h", dut_params(), e.params);
        end
        check("pending", {31'd0, commit_pending}, {31'd0, e.pend});
        check("rdata", {24'd0, reg_rdata}, {24'd0, e.rd});
        check("rd_hit", {31'd0, rd_hit}, {31'd0, e.hit});
        $display("txn we=%0b addr=%h data=%h render=%0b dot=%0d ra=%h a=%h pend=%0b rd=%h",
                 reg_we, reg_addr, reg_wdata, render, dot_ctr, rd_addr, m7_a,
                 commit_pending, reg_rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] rand_addrs [12] = '{8'h0D, 8'h0E, 8'h1A, 8'h1B, 8'h1C, 8'h1D,
                                  8'h1E, 8'h1F, 8'h20, 8'h00, 8'h21, 8'h34};

  initial begin
    int budget;
    model_clear();
    reset = 1'b0;
    rd_addr = 8'h34;
    repeat (3) @(posedge clk);
    #1;
    check("reset_params", 32'(dut_params() != '0), 32'd0);
    check("reset_rdata", {24'd0, reg_rdata}, 32'h0);
    check("reset_pending", {31'd0, commit_pending}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Latch pairing
    step(1, 8'h1B, 8'h34, 0, 0, 8'h00);
    step(1, 8'h1B, 8'h12, 0, 0, 8'h00);
    after_edge();
    check("latch_pair_a", {16'd0, m7_a}, 32'h1234);

    // Product read-back: A = FF00 (-256), B high = 3
    step(1, 8'h1B, 8'h00, 0, 0, 8'h34);
    step(1, 8'h1B, 8'hFF, 0, 0, 8'h34);
    step(1, 8'h1C, 8'h00, 0, 0, 8'h34);
    step(1, 8'h1C, 8'h03, 0, 0, 8'h34);
    after_edge();
    check("mpy_l", {24'd0, reg_rdata}, 32'h00);
    step(0, 8'h00, 8'h00, 0, 0, 8'h35);
    after_edge();
    check("mpy_m", {24'd0, reg_rdata}, 32'hFD);
    step(0, 8'h00, 8'h00, 0, 0, 8'h36);
    after_edge();
    check("mpy_h", {24'd0, reg_rdata}, 32'hFF);

    // Mid-dot commit: C written during a dot group, held until dot 7
    step(1, 8'h1D, 8'h78, 1, 1, 8'h00);
    step(1, 8'h1D, 8'h56, 1, 2, 8'h00);
    after_edge();
    check("middot_hold_c", {16'd0, m7_c}, 32'h0000);
    check("middot_pending", {31'd0, commit_pending}, 32'h1);
    for (int k = 3; k < 7; k++) step(0, 8'h00, 8'h00, 1, 3'(k), 8'h00);
    after_edge();
    check("middot_still_c", {16'd0, m7_c}, 32'h0000);
    step(0, 8'h00, 8'h00, 1, 7, 8'h00);
    after_edge();
    check("middot_commit_c", {16'd0, m7_c}, 32'h5678);
    check("middot_clear", {31'd0, commit_pending}, 32'h0);

    // Write during commit: second $20 byte on dot 7
    step(1, 8'h20, 8'hAB, 1, 7, 8'h00);
    for (int k = 0; k < 7; k++) step(0, 8'h00, 8'h00, 1, 3'(k), 8'h00);
    step(1, 8'h20, 8'hFC, 1, 7, 8'h00);
    after_edge();
    check("wcommit_yorig", {19'd0, m7_yorig}, 32'h1CAB);
    check("wcommit_pending", {31'd0, commit_pending}, 32'h0);

    // M7SEL mapping and latch bypass
    step(1, 8'h1B, 8'h77, 0, 0, 8'h34);
    step(1, 8'h1A, 8'hC3, 0, 0, 8'h34);
    step(1, 8'h1B, 8'h21, 0, 0, 8'h34);
    after_edge();
    check("m7sel_map", {28'd0, m7sel}, 32'hF);
    check("sel_bypass_a", {16'd0, m7_a}, 32'h2177);

    // Reset mid-operation, between the two writes of a pair
    step(1, 8'h1B, 8'h99, 0, 0, 8'h34);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_clear();
    check("areset_params", 32'(dut_params() != '0), 32'd0);
    check("areset_rdata", {24'd0, reg_rdata}, 32'h0);
    step(0, 8'h00, 8'h00, 0, 0, 8'h34);
    @(negedge clk);
    reset = 1'b1;
    model_step(0, 8'h00, 8'h00, 0, 0, 8'h34);
    step(1, 8'h1B, 8'h55, 0, 0, 8'h34);
    after_edge();
    check("post_reset_a", {16'd0, m7_a}, 32'h5500);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), rand_addrs[$urandom_range(0, 11)],
           8'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom),
           8'($urandom_range(8'h33, 8'h37)));
    end
    step(0, 8'h00, 8'h00, 0, 0, 8'h00);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
